multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencer for the MIPS datapath. Replaces single-cycle opcode decode with a Moore FSM (plus MemReady-qualified strobes) that steps each instruction through fetch, decode, execute, memory and writeback over shared ALU/memory resources. Sits beside the register file, ALU and unified instruction/data memory, driving their mux selects and write enables each cycle. Stretches memory states under a MemReady handshake.

## Interface
Parameters:
- none. Opcodes, ALUOp codes and state encoding are fixed localparams.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- OP  in  6  opcode from instruction register; stable from DECODE until the next FETCH completes
- Zero  in  1  ALU zero flag; the branch decision is made outside this block
- MemReady  in  1  memory completes the current access this cycle
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  load instruction register
- PCWrite  out  1  unconditional PC write
- BranchEQ  out  1  conditional PC write if Zero
- BranchNE  out  1  conditional PC write if !Zero
- PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- ALUSrcA  out  1  0 = PC, 1 = rs
- ALUSrcB  out  2  00 = rt, 01 = constant 4, 10 = extended imm, 11 = imm<<2
- ALUOp  out  3  100 = add, 101 = or, 110 = sub, 111 = R-type funct
- ExtendSide  out  1  place immediate in the upper half (LUI)
- RegWrite  out  1  register file write
- RegDst  out  1  1 = rd, 0 = rt
- MemtoReg  out  1  1 = MDR, 0 = ALUOut
- InstrDone  out  1  one-cycle pulse in the final state of each instruction
- IllegalOp  out  1  one-cycle pulse when DECODE sees an unsupported opcode

## Operation
Supported opcodes: R-type 00, J 02, BEQ 04, BNE 05, ADDI 08, ORI 0D, LUI 0F, LW 23, SW 2B.

States and their asserted outputs (all other outputs 0):
- IDLE: all outputs 0. Always goes to FETCH.
- FETCH: MemRead, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 100, PCSrc = 00.
  - IRWrite and PCWrite are asserted only while MemReady = 1.
  - Stays in FETCH while MemReady = 0; goes to DECODE when MemReady = 1.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 100 (branch target into ALUOut). Next state by OP:
  - LW/SW → MEMADR
  - R-type → EXEC
  - ADDI/ORI/LUI → IEXEC
  - BEQ/BNE → BRANCH
  - J → JUMP
  - any other opcode → FETCH, with IllegalOp pulsed
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 100. LW → MEMRD, SW → MEMWR.
- MEMRD: MemRead, IorD = 1. Waits for MemReady = 1, then MEMWB.
- MEMWB: RegWrite, RegDst = 0, MemtoReg = 1, InstrDone. Next state FETCH.
- MEMWR: MemWrite, IorD = 1. Waits for MemReady = 1, then FETCH; InstrDone is pulsed in the cycle where MemReady = 1.
- EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 111. Next state RWB.
- RWB: RegWrite, RegDst = 1, MemtoReg = 0, InstrDone. Next state FETCH.
- IEXEC: ALUSrcA = 1, ALUSrcB = 10. ALUOp = 100 (ADDI, LUI) or 101 (ORI); ExtendSide = 1 for LUI only. Next state IWB.
- IWB: RegWrite, RegDst = 0, MemtoReg = 0, ExtendSide held as in IEXEC, InstrDone. Next state FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 110, PCSrc = 01.
  - BranchEQ for BEQ, BranchNE for BNE.
  - InstrDone. Next state FETCH.
- JUMP: PCWrite, PCSrc = 10, InstrDone. Next state FETCH.

Rules:
- No output may be X in any state.
- MemRead and MemWrite are never asserted together.

## Timing
- While reset = 0, the state is IDLE and every output is 0. The first FETCH occurs one cycle after reset deasserts.
- Cycles per instruction with MemReady held at 1:
  - LW: 5
  - R-type, ADDI, ORI, LUI, SW: 4
  - BEQ, BNE, J: 3
- Each MemReady = 0 cycle in FETCH, MEMRD or MEMWR adds one cycle. The request and its address/select outputs stay stable while waiting.
- Asserting reset in any state, including during a wait, returns to IDLE immediately. No partial write strobe survives.
- OP is sampled only in DECODE. Later states use an internally registered copy, so IR glitches after DECODE cannot redirect the FSM.

## Structure
- Shared include file holds:
  - opcode localparams
  - ALUOp codes (100/101/110/111)
  - PCSrc and ALUSrcB encodings
  - the 13-state encoding (4 bits)
- Sub-module: none. The next-state process and the output decode (a case on state) stay in one module. Registered state and OP copy; outputs decoded combinationally.

## Test plan
- Reset: hold reset = 0 for 3 cycles → all outputs 0. Release → IDLE for 1 cycle, then FETCH with MemRead = 1, ALUSrcB = 01.
- R-type, MemReady = 1, OP = 00: 4 cycles.
  - EXEC shows ALUOp = 111.
  - RWB shows RegWrite = 1, RegDst = 1, InstrDone = 1.
- LW, OP = 23, MemReady = 0 for 2 cycles in MEMRD:
  - MEMRD is held 3 cycles with IorD = 1, MemRead = 1.
  - MEMWB shows MemtoReg = 1.
  - Total 7 cycles.
- BNE, OP = 05:
  - DECODE shows ALUSrcB = 11.
  - BRANCH shows BranchNE = 1, BranchEQ = 0, PCSrc = 01, ALUOp = 110.
  - Back to FETCH on the 4th cycle.
- LUI then ORI: LUI IEXEC/IWB show ExtendSide = 1, ALUOp = 100; ORI IEXEC shows ALUOp = 101, ExtendSide = 0.
- Illegal opcode and mid-access reset:
  - OP = 3F → IllegalOp pulses in DECODE, then FETCH, with RegWrite, MemWrite and PCWrite never asserted.
  - Reset asserted during a MEMWR wait → MemWrite drops to 0 in the same cycle.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_control_pkg
//   Shared definitions for the multi-cycle MIPS sequencer:
//   - supported opcodes
//   - ALUOp, PCSrc and ALUSrcB encodings
//   - the 13-state FSM encoding (4 bits)
//   - a packed bundle of every control output
//   - a helper that reports whether an opcode is implemented
// -----------------------------------------------------------------------------
package multicycle_control_pkg;

    // Opcodes handled by the sequencer
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // ALU operation requests
    localparam logic [2:0] ALUOP_ADD   = 3'b100;
    localparam logic [2:0] ALUOP_OR    = 3'b101;
    localparam logic [2:0] ALUOP_SUB   = 3'b110;
    localparam logic [2:0] ALUOP_FUNCT = 3'b111;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU B operand select
    localparam logic [1:0] ALUSRCB_RT       = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR     = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM      = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SHL2 = 2'b11;

    // Sequencer states
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_EXEC   = 4'd7,
        ST_RWB    = 4'd8,
        ST_IEXEC  = 4'd9,
        ST_IWB    = 4'd10,
        ST_BRANCH = 4'd11,
        ST_JUMP   = 4'd12
    } state_e;

    // All control outputs in one bundle so a single default clears them
    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       branch_eq;
        logic       branch_ne;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       extend_side;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    // True for every opcode the sequencer knows how to step through
    function automatic logic op_supported(input logic [5:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI,
            OP_ORI, OP_LUI, OP_LW, OP_SW: ok = 1'b1;
            default:                      ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Moore sequencer for a multi-cycle MIPS datapath.
//   Each instruction is stepped through fetch, decode, execute, memory and
//   writeback. Memory states stretch until MemReady.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   OP         : opcode from the instruction register (sampled in DECODE)
//   Zero       : ALU zero flag (branch resolved outside this block)
//   MemReady   : memory completes the current access this cycle
//   IorD, MemRead, MemWrite, IRWrite, PCWrite, BranchEQ, BranchNE,
//   PCSrc[1:0], ALUSrcA, ALUSrcB[1:0], ALUOp[2:0], ExtendSide,
//   RegWrite, RegDst, MemtoReg : datapath selects and strobes
//   InstrDone  : pulse in the final state of each instruction
//   IllegalOp  : pulse when DECODE sees an unsupported opcode
// -----------------------------------------------------------------------------
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OP,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       BranchEQ,
    output logic       BranchNE,
    output logic [1:0] PCSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       ExtendSide,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       InstrDone,
    output logic       IllegalOp
);

    state_e      state_q;
    state_e      state_d;
    logic [5:0]  op_q;
    ctrl_t       ctrl;

    // The branch condition is applied in the datapath; the flag is only
    // present on this block's boundary.
    logic unused_zero;
    assign unused_zero = Zero;

    // -------------------------------------------------------------------------
    // State register and opcode copy. The opcode is captured on the DECODE
    // edge so later states ignore any change on the IR output.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_q    <= 6'h00;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                op_q <= OP;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH:  state_d = MemReady ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (OP)
                    OP_LW, OP_SW:           state_d = ST_MEMADR;
                    OP_RTYPE:               state_d = ST_EXEC;
                    OP_ADDI, OP_ORI, OP_LUI: state_d = ST_IEXEC;
                    OP_BEQ, OP_BNE:         state_d = ST_BRANCH;
                    OP_J:                   state_d = ST_JUMP;
                    default:                state_d = ST_FETCH;
                endcase
            end
            // Only LW and SW reach MEMADR, so anything not SW is a load.
            ST_MEMADR: state_d = (op_q == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:  state_d = MemReady ? ST_MEMWB : ST_MEMRD;
            ST_MEMWB:  state_d = ST_FETCH;
            ST_MEMWR:  state_d = MemReady ? ST_FETCH : ST_MEMWR;
            ST_EXEC:   state_d = ST_RWB;
            ST_RWB:    state_d = ST_FETCH;
            ST_IEXEC:  state_d = ST_IWB;
            ST_IWB:    state_d = ST_FETCH;
            ST_BRANCH: state_d = ST_FETCH;
            ST_JUMP:   state_d = ST_FETCH;
            default:   state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode. Everything defaults to 0, so each state lists only
    // what it asserts.
    // -------------------------------------------------------------------------
    always_comb begin
        ctrl = '0;
        case (state_q)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.iord      = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = ALUSRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_src    = PCSRC_ALU;
                // IR load and PC+4 commit only when the fetch returns.
                ctrl.ir_write  = MemReady;
                ctrl.pc_write  = MemReady;
            end
            ST_DECODE: begin
                // Branch target computed speculatively into ALUOut.
                ctrl.alu_src_a  = 1'b0;
                ctrl.alu_src_b  = ALUSRCB_IMM_SHL2;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.illegal_op = !op_supported(OP);
            end
            ST_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            ST_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_MEMWR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.iord       = 1'b1;
                // The store retires in the cycle the memory accepts it.
                ctrl.instr_done = MemReady;
            end
            ST_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSRCB_RT;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_RWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
                ctrl.instr_done = 1'b1;
            end
            ST_IEXEC: begin
                ctrl.alu_src_a   = 1'b1;
                ctrl.alu_src_b   = ALUSRCB_IMM;
                ctrl.alu_op      = (op_q == OP_ORI) ? ALUOP_OR : ALUOP_ADD;
                ctrl.extend_side = (op_q == OP_LUI);
            end
            ST_IWB: begin
                ctrl.reg_write   = 1'b1;
                ctrl.reg_dst     = 1'b0;
                ctrl.mem_to_reg  = 1'b0;
                // Keep the immediate placement stable through writeback.
                ctrl.extend_side = (op_q == OP_LUI);
                ctrl.instr_done  = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = ALUSRCB_RT;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.pc_src     = PCSRC_ALUOUT;
                ctrl.branch_eq  = (op_q == OP_BEQ);
                ctrl.branch_ne  = (op_q == OP_BNE);
                ctrl.instr_done = 1'b1;
            end
            ST_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_src     = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    assign IorD       = ctrl.iord;
    assign MemRead    = ctrl.mem_read;
    assign MemWrite   = ctrl.mem_write;
    assign IRWrite    = ctrl.ir_write;
    assign PCWrite    = ctrl.pc_write;
    assign BranchEQ   = ctrl.branch_eq;
    assign BranchNE   = ctrl.branch_ne;
    assign PCSrc      = ctrl.pc_src;
    assign ALUSrcA    = ctrl.alu_src_a;
    assign ALUSrcB    = ctrl.alu_src_b;
    assign ALUOp      = ctrl.alu_op;
    assign ExtendSide = ctrl.extend_side;
    assign RegWrite   = ctrl.reg_write;
    assign RegDst     = ctrl.reg_dst;
    assign MemtoReg   = ctrl.mem_to_reg;
    assign InstrDone  = ctrl.instr_done;
    assign IllegalOp  = ctrl.illegal_op;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//   Directed and randomized instruction streams. Each instruction is expanded
//   by the bench into its list of steps (control word, whether it waits for
//   MemReady, and the bits that only appear when MemReady is high). Every DUT
//   cycle is compared against that plan.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OP;
    logic       Zero;
    logic       MemReady;
    logic       IorD, MemRead, MemWrite, IRWrite, PCWrite, BranchEQ, BranchNE;
    logic [1:0] PCSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic       ExtendSide, RegWrite, RegDst, MemtoReg, InstrDone, IllegalOp;

    multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .OP         (OP),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .BranchEQ   (BranchEQ),
        .BranchNE   (BranchNE),
        .PCSrc      (PCSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .ExtendSide (ExtendSide),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .InstrDone  (InstrDone),
        .IllegalOp  (IllegalOp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       iord, memread, memwrite, irwrite, pcwrite, beq, bne;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluop;
        logic       ext, regwrite, regdst, memtoreg, done, illegal;
    } ctl_t;

    typedef struct packed {
        ctl_t base;   // asserted for the whole step
        ctl_t extra;  // added only in the cycle MemReady = 1
        logic waits;  // step stretches until MemReady = 1
        logic mem;    // data-memory wait (as opposed to instruction fetch)
    } step_t;

    step_t plan_q[$];
    int    checks   = 0;
    int    failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic ctl_t observed();
        return ctl_t'({IorD, MemRead, MemWrite, IRWrite, PCWrite, BranchEQ, BranchNE,
                       PCSrc, ALUSrcA, ALUSrcB, ALUOp,
                       ExtendSide, RegWrite, RegDst, MemtoReg, InstrDone, IllegalOp});
    endfunction

    function automatic bit legal(input logic [5:0] op);
        case (op)
            6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h0F, 6'h23, 6'h2B: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic push(input ctl_t b, input ctl_t e, input bit w, input bit m);
        step_t s;
        s.base = b; s.extra = e; s.waits = w; s.mem = m;
        plan_q.push_back(s);
    endtask

    // Expand one instruction into the sequence of control words it must show.
    task automatic plan(input logic [5:0] op);
        ctl_t b, e;
        plan_q.delete();
        // fetch: read PC, PC+4 in the ALU; IR/PC commit when memory answers
        b = '0; e = '0;
        b.memread = 1; b.alusrcb = 2'b01; b.aluop = 3'b100;
        e.irwrite = 1; e.pcwrite = 1;
        push(b, e, 1, 0);
        // decode: branch target PC + (imm<<2)
        b = '0; e = '0;
        b.alusrcb = 2'b11; b.aluop = 3'b100; b.illegal = !legal(op);
        push(b, e, 0, 0);
        b = '0; e = '0;
        case (op)
            6'h23, 6'h2B: begin
                b.alusrca = 1; b.alusrcb = 2'b10; b.aluop = 3'b100;
                push(b, e, 0, 0);
                b = '0;
                if (op == 6'h23) begin
                    b.memread = 1; b.iord = 1;
                    push(b, e, 1, 1);
                    b = '0;
                    b.regwrite = 1; b.memtoreg = 1; b.done = 1;
                    push(b, e, 0, 0);
                end else begin
                    b.memwrite = 1; b.iord = 1; e.done = 1;
                    push(b, e, 1, 1);
                end
            end
            6'h00: begin
                b.alusrca = 1; b.aluop = 3'b111;
                push(b, e, 0, 0);
                b = '0;
                b.regwrite = 1; b.regdst = 1; b.done = 1;
                push(b, e, 0, 0);
            end
            6'h08, 6'h0D, 6'h0F: begin
                b.alusrca = 1; b.alusrcb = 2'b10;
                b.aluop = (op == 6'h0D) ? 3'b101 : 3'b100;
                b.ext = (op == 6'h0F);
                push(b, e, 0, 0);
                b = '0;
                b.regwrite = 1; b.ext = (op == 6'h0F); b.done = 1;
                push(b, e, 0, 0);
            end
            6'h04, 6'h05: begin
                b.alusrca = 1; b.aluop = 3'b110; b.pcsrc = 2'b01;
                b.beq = (op == 6'h04); b.bne = (op == 6'h05); b.done = 1;
                push(b, e, 0, 0);
            end
            6'h02: begin
                b.pcwrite = 1; b.pcsrc = 2'b10; b.done = 1;
                push(b, e, 0, 0);
            end
            default: ;
        endcase
    endtask

    // Drive reset low mid-cycle and confirm outputs clear at once, then
    // release and confirm one IDLE cycle before the next fetch.
    task automatic do_reset(input string why);
        reset = 1'b0;
        #1;
        check_val({why, "_async"}, 32'(observed()), 32'd0);
        @(posedge clk); #1;
        check_val({why, "_hold"}, 32'(observed()), 32'd0);
        reset = 1'b1;
        #1;
        check_val({why, "_idle"}, 32'(observed()), 32'd0);
        @(posedge clk); #1;
    endtask

    // Run one instruction starting in FETCH. rand_mr: random MemReady;
    // otherwise MemReady is 1 except for 'stall' cycles of the memory wait.
    // abort: reset the DUT during the first memory wait cycle.
    task automatic run_instr(input logic [5:0] op, input bit rand_mr, input int stall, input bit abort);
        int   dones  = 0;
        int   cycles = 0;
        ctl_t got, exp;
        plan(op);
        for (int i = 0; i < plan_q.size(); i++) begin
            int waited = 0;
            forever begin
                bit mr;
                if (rand_mr) mr = ($urandom_range(0, 2) != 0);
                else         mr = !(plan_q[i].mem && waited < stall);
                if (plan_q[i].waits && waited >= 12) mr = 1'b1;
                MemReady = mr;
                Zero     = 1'($urandom);
                OP       = (i == 1) ? op : 6'($urandom);
                #1;
                got = observed();
                exp = plan_q[i].base | (mr ? plan_q[i].extra : ctl_t'(0));
                check_val($sformatf("op%02h_step%0d_c%0d", op, i, cycles), 32'(got), 32'(exp));
                dones += int'(got.done);
                cycles++;
                if (abort && plan_q[i].mem && !mr) begin
                    $display("instr op=%02h aborted by reset after %0d cycles", op, cycles);
                    do_reset("midreset");
                    return;
                end
                @(posedge clk); #1;
                if (!plan_q[i].waits || mr) break;
                waited++;
            end
        end
        check_val($sformatf("op%02h_done_cnt", op), 32'(dones), legal(op) ? 32'd1 : 32'd0);
        $display("instr op=%02h cycles=%0d done=%0d", op, cycles, dones);
    endtask

    logic [5:0] op_tab [9] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h0F, 6'h23, 6'h2B};

    initial begin
        reset    = 1'b0;
        OP       = 6'h00;
        Zero     = 1'b0;
        MemReady = 1'b0;
        #2;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_val($sformatf("reset_c%0d", i), 32'(observed()), 32'd0);
        end
        reset = 1'b1;
        #1;
        check_val("post_reset_idle", 32'(observed()), 32'd0);
        @(posedge clk); #1;

        // directed sequences
        run_instr(6'h00, 0, 0, 0);   // R-type
        run_instr(6'h23, 0, 2, 0);   // LW with two-cycle MEMRD stall
        run_instr(6'h05, 0, 0, 0);   // BNE
        run_instr(6'h0F, 0, 0, 0);   // LUI
        run_instr(6'h0D, 0, 0, 0);   // ORI
        run_instr(6'h3F, 0, 0, 0);   // illegal opcode
        run_instr(6'h2B, 0, 1, 0);   // SW with a stall
        run_instr(6'h2B, 0, 2, 1);   // reset during MEMWR wait
        run_instr(6'h04, 0, 0, 0);   // BEQ after reset recovery

        // randomized stream
        for (int n = 0; n < 150; n++) begin
            logic [5:0] op;
            if ($urandom_range(0, 3) == 0) op = 6'($urandom);
            else                           op = op_tab[$urandom_range(0, 8)];
            run_instr(op, 1, 0, ($urandom_range(0, 19) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
